// File: rtl/ram_ctl_pkg.sv
// ram_ctl_pkg: shared definitions for the 32Kx12 static-RAM sequencer.
//   - request op encodings (op 2'b11 is decoded as a read)
//   - sequencer state encoding
//   - width of the shared wait/pulse down-counter
package ram_ctl_pkg;

  localparam int CNT_W = 4;

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_RMW   = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_READ   = 3'd1,
    ST_WSETUP = 3'd2,
    ST_WPULSE = 3'd3,
    ST_WHOLD  = 3'd4
  } state_e;

endpackage

// File: rtl/ram_ctl.sv
// ram_ctl: sequencer for the CPU's asynchronous 32Kx12 static RAM.
// Accepts single-word read, write and read-increment-write (RMW) requests
// with field-extended 15-bit addresses and produces CE_N/WE_N timing with
// programmable read wait (RD_WAIT) and write pulse width (WE_WIDTH), 1..15.
//
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   req, op             request strobe (sampled only while ready) and type
//   field, addr, wdata  memory field, word address, write data
//   ready, done         idle indicator, one-cycle completion pulse
//   rdata, incz         captured read data, RMW-result-is-zero flag
//   ram_a, ram_di       RAM address and write data
//   ram_ce_n, ram_we_n  RAM chip enable / write enable, active low
//   ram_do              RAM read data
//
// state     | meaning
// ----------+---------------------------------------------------------
// ST_IDLE   | waiting for req; CE_N and WE_N high
// ST_READ   | CE_N low, counting down RD_WAIT; capture ram_do at zero
// ST_WSETUP | address/data settled with CE_N low, WE_N still high
// ST_WPULSE | WE_N low, counting down WE_WIDTH
// ST_WHOLD  | WE_N high again, address/data held one more cycle
module ram_ctl
  import ram_ctl_pkg::*;
#(
  parameter int RD_WAIT  = 1,
  parameter int WE_WIDTH = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic [1:0]  op,
  input  logic [2:0]  field,
  input  logic [11:0] addr,
  input  logic [11:0] wdata,
  output logic        ready,
  output logic        done,
  output logic [11:0] rdata,
  output logic        incz,
  output logic [14:0] ram_a,
  output logic [11:0] ram_di,
  output logic        ram_ce_n,
  output logic        ram_we_n,
  input  logic [11:0] ram_do
);

  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_WAIT - 1);
  localparam logic [CNT_W-1:0] WE_LOAD = CNT_W'(WE_WIDTH - 1);

  state_e           state;
  logic [CNT_W-1:0] cnt;
  logic             is_rmw;

  assign ready = (state == ST_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      is_rmw   <= 1'b0;
      done     <= 1'b0;
      rdata    <= '0;
      incz     <= 1'b0;
      ram_ce_n <= 1'b1;
      ram_we_n <= 1'b1;
      // A write strobe cut short by reset must not see its address or data
      // move on the same edge that raises WE_N; clear them one edge later.
      if (ram_we_n) begin
        ram_a  <= '0;
        ram_di <= '0;
      end
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req) begin
            ram_a    <= {field, addr};
            ram_ce_n <= 1'b0;
            is_rmw   <= (op == OP_RMW);
            if (op == OP_WRITE) begin
              ram_di <= wdata;
              state  <= ST_WSETUP;
            end else begin
              cnt   <= RD_LOAD;
              state <= ST_READ;
            end
          end
        end
        ST_READ: begin
          if (cnt == '0) begin
            rdata <= ram_do;
            if (is_rmw) begin
              ram_di <= ram_do + 12'd1;
              incz   <= (ram_do == 12'o7777);
              state  <= ST_WSETUP;
            end else begin
              incz     <= 1'b0;
              done     <= 1'b1;
              ram_ce_n <= 1'b1;
              state    <= ST_IDLE;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_WSETUP: begin
          ram_we_n <= 1'b0;
          cnt      <= WE_LOAD;
          state    <= ST_WPULSE;
        end
        ST_WPULSE: begin
          if (cnt == '0) begin
            ram_we_n <= 1'b1;
            state    <= ST_WHOLD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_WHOLD: begin
          ram_ce_n <= 1'b1;
          done     <= 1'b1;
          if (!is_rmw) incz <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/ram_ctl.md
# ram_ctl

Synchronous memory sequencer that drives the CPU's asynchronous 32Kx12 static RAM on the initiator side of its A/DI/DO/CE_N/WE_N interface. It accepts single-word read, write and read-increment-write requests from the CPU, using field-extended 15-bit addresses. It generates glitch-free chip-enable and write-enable sequencing with programmable wait and pulse widths, and returns read data with a one-cycle completion strobe. Read-increment-write serves ISZ and auto-index locations 0o0010–0o0017.

## Interface
- RD_WAIT, 1: cycles CE_N is held low before read data is captured; legal range 1–15.
- WE_WIDTH, 1: cycles WE_N is held low during a write; legal range 1–15.

- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req  in  1  request strobe; sampled only while ready=1.
- op  in  2  request type: 00 read, 01 write, 10 read-increment-write (RMW), 11 treated as read.
- field  in  3  memory field; becomes ram_a[14:12].
- addr  in  12  word address; becomes ram_a[11:0].
- wdata  in  12  write data for op 01.
- ready  out  1  high in IDLE; request may be accepted.
- done  out  1  one-cycle completion pulse.
- rdata  out  12  captured read data (for RMW, the pre-increment value); held until the next capture.
- incz  out  1  on RMW completion, 1 if the incremented value is 0o0000; cleared on read/write completion.
- ram_a  out  15  RAM address.
- ram_di  out  12  RAM write data.
- ram_ce_n  out  1  RAM chip enable, active low.
- ram_we_n  out  1  RAM write enable, active low.
- ram_do  in  12  RAM read data.

## Operation
- States: IDLE, READ, WSETUP, WPULSE, WHOLD. A 4-bit down-counter times READ and WPULSE.
- IDLE with req=1 (edge 0): latch ram_a={field,addr} and set ram_ce_n=0.
  - op 01: ram_di=wdata, go to WSETUP.
  - Otherwise: go to READ with count=RD_WAIT-1.
- READ: exit when count=0.
  - Read: rdata<=ram_do, incz<=0, done<=1, go to IDLE.
  - RMW: rdata<=ram_do, ram_di<=(ram_do+1) mod 4096, incz<=(ram_do==0o7777), go to WSETUP.
- WSETUP: one cycle. ram_we_n<=0, count=WE_WIDTH-1, go to WPULSE.
- WPULSE: when count=0, ram_we_n<=1 and go to WHOLD.
- WHOLD: one cycle. ram_ce_n<=1 and done<=1 (incz<=0 for plain writes), go to IDLE.
- READ exit to IDLE also sets ram_ce_n<=1.
- ready = (state==IDLE). A req during the done cycle is accepted, giving back-to-back operation. A req while busy is ignored, with no queueing.
- Invariants:
  - ram_we_n=0 implies ram_ce_n=0.
  - ram_a and ram_di never change while ram_we_n=0.
  - ram_a and ram_di are stable for the entire CE-low window of a write.
- Increment arithmetic is 12-bit with wrap; the carry is discarded and reported only through incz.

## Timing
- Reset values: state IDLE, ready 1, done 0, rdata 0, incz 0, ram_ce_n 1, ram_we_n 1, ram_a 0, ram_di 0.
- Reset mid-operation:
  - ram_ce_n and ram_we_n go to 1 at the first reset edge.
  - If ram_we_n was 0 before that edge, ram_a and ram_di hold their value for that edge and clear on the next reset-asserted edge.
  - The in-flight operation is abandoned and no done pulse is issued.
- Latency, counted from the acceptance edge 0 to the edge that raises done:
  - Read: RD_WAIT edges.
  - Write: WE_WIDTH+2 edges.
  - RMW: RD_WAIT+WE_WIDTH+2 edges.
- ram_do is sampled on the last READ edge, giving RD_WAIT full cycles of address-stable access.
- done is high for exactly one cycle. rdata and incz are valid in that cycle and remain until the next capture.

## Structure
- Shared package ram_ctl_pkg holds:
  - op encodings OP_READ=2'b00, OP_WRITE=2'b01, OP_RMW=2'b10;
  - the state enum;
  - the counter width constant (4).
- Single module; the wait counter is inline. No sub-module is warranted.

## Test plan
- Write then read: write 0o5177 at field 0, addr 0o0200 → ram_we_n low for exactly 1 cycle with ram_a=0o00200. A later read returns rdata=0o5177 with one done pulse.
- Field mapping: read field 3, addr 0o0123 → ram_a=0o30123 throughout READ. Data is captured RD_WAIT edges after acceptance.
- RMW wrap: location 0o0010 holds 0o7777 → rdata=0o7777, memory becomes 0o0000, incz=1. A second RMW gives rdata=0o0000, memory 0o0001, incz=0.
- Back-to-back: issue a read with req held through the done cycle → a second write starts the next edge. ram_a/ram_di never change while ram_we_n=0 (assertion checked continuously).
- Busy and reserved op: a req pulse during WPULSE is ignored and memory is unchanged. op 11 behaves as a read.
- Reset in WPULSE with WE_WIDTH=4: ram_we_n and ram_ce_n rise at the reset edge while ram_a holds that edge. No done pulse is issued, and ready=1 after reset.
